// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer: default geometry,
// control-code values and the writer state encoding.
package text_console_writer_pkg;

    // Default text geometry: 1024x768 pixels with 8x16 glyphs
    localparam int TXT_WIDTH  = 128;
    localparam int TXT_HEIGHT = 48;
    localparam int TXT_CHAR_W = 8;

    // Control codes recognised by the writer
    localparam logic [7:0] TXT_BLANK = 8'h00;
    localparam logic [7:0] TXT_NL    = 8'h0A;
    localparam logic [7:0] TXT_CR    = 8'h0D;
    localparam logic [7:0] TXT_BS    = 8'h08;

    // Writer states; the encoding is also exported on the debug port
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR_LINE = 2'd1,
        ST_CLEAR_ALL  = 2'd2
    } txt_state_e;

endpackage

// File: rtl/text_sweep_counter.sv
// Column/row counter used to sweep blank writes over either one row
// (row_only) or the whole screen in row-major order. start reloads the
// counter; step advances it; done flags the final position of the sweep.
module text_sweep_counter #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 48,
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          row_only_i,
    input  logic [YW-1:0] row_i,
    input  logic          step_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          done_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          row_only_q, row_only_d;

    // Next position: start wins over step; rows wrap explicitly at HEIGHT-1
    // because HEIGHT need not be a power of two.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        row_only_d = row_only_q;
        if (start_i) begin
            x_d        = '0;
            y_d        = row_only_i ? row_i : '0;
            row_only_d = row_only_i;
        end else if (step_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (!row_only_q) begin
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Counter registers; reset leaves a full-screen sweep armed at (0,0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            row_only_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_only_q <= row_only_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = (x_q == X_LAST) && (row_only_q || (y_q == Y_LAST));

endmodule

// File: rtl/text_console_writer.sv
// Terminal-style character writer feeding the write port of screen_buf.
// Places accepted codes at the cursor, handles NL/CR/BS, wraps at the
// right edge and bottom row (blanking each newly entered row) and runs a
// full-screen blanking sweep after reset and whenever clear is pulsed.
//
// Handshake: a character transfers on a rising clk edge where
// char_valid && char_ready; char_ready is combinational and is high only in
// IDLE while clear is low. There is no backpressure on the write port.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int WIDTH      = TXT_WIDTH,
    parameter int HEIGHT     = TXT_HEIGHT,
    parameter int CHAR_WIDTH = TXT_CHAR_W,
    parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR = CHAR_WIDTH'(TXT_BLANK),
    parameter logic [CHAR_WIDTH-1:0] NL_CHAR    = CHAR_WIDTH'(TXT_NL),
    parameter logic [CHAR_WIDTH-1:0] CR_CHAR    = CHAR_WIDTH'(TXT_CR),
    parameter logic [CHAR_WIDTH-1:0] BS_CHAR    = CHAR_WIDTH'(TXT_BS),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  char_valid,
    input  logic [CHAR_WIDTH-1:0] char_in,
    output logic                  char_ready,
    output logic                  write_en,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [CHAR_WIDTH-1:0] c_out,
    output logic [XW-1:0]         cursor_x,
    output logic [YW-1:0]         cursor_y,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    txt_state_e            state_q;
    logic                  write_en_q;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic [CHAR_WIDTH-1:0] c_q;
    logic [XW-1:0]         cursor_x_q;
    logic [YW-1:0]         cursor_y_q;
    // Marks that the registered write belongs to a full-screen sweep, so
    // busy also covers the final sweep write after the FSM returns to IDLE.
    logic                  sweep_wr_q;

    logic                  accept;
    logic                  is_nl, is_cr, is_bs, is_print;
    logic [YW-1:0]         cursor_y_inc;

    logic                  cnt_start, cnt_row_only, cnt_step, cnt_done;
    logic [XW-1:0]         cnt_x;
    logic [YW-1:0]         cnt_y;

    assign char_ready   = (state_q == ST_IDLE) && !clear;
    assign accept       = char_valid && char_ready;
    assign is_nl        = (char_in == NL_CHAR);
    assign is_cr        = (char_in == CR_CHAR);
    assign is_bs        = (char_in == BS_CHAR);
    assign is_print     = !(is_nl || is_cr || is_bs);
    assign cursor_y_inc = (cursor_y_q == Y_LAST) ? '0 : cursor_y_q + 1'b1;

    // Sweep counter control: clear restarts a full sweep; entering a new
    // row arms a single-row sweep; both clear states step every cycle.
    always_comb begin
        cnt_start    = 1'b0;
        cnt_row_only = 1'b0;
        cnt_step     = 1'b0;
        if (clear) begin
            cnt_start = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (is_nl || (is_print && cursor_x_q == X_LAST))) begin
                        cnt_start    = 1'b1;
                        cnt_row_only = 1'b1;
                    end
                end
                ST_CLEAR_LINE, ST_CLEAR_ALL: cnt_step = 1'b1;
                default: ;
            endcase
        end
    end

    text_sweep_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_sweep (
        .clk        (clk),
        .rst        (reset),
        .start_i    (cnt_start),
        .row_only_i (cnt_row_only),
        .row_i      (cursor_y_inc),
        .step_i     (cnt_step),
        .x_o        (cnt_x),
        .y_o        (cnt_y),
        .done_o     (cnt_done)
    );

    // Writer FSM with registered write port and cursor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR_ALL;
            write_en_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            c_q        <= BLANK_CHAR;
            cursor_x_q <= '0;
            cursor_y_q <= '0;
            sweep_wr_q <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            sweep_wr_q <= 1'b0;
            if (clear) begin
                state_q    <= ST_CLEAR_ALL;
                cursor_x_q <= '0;
                cursor_y_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (is_nl) begin
                                cursor_x_q <= '0;
                                cursor_y_q <= cursor_y_inc;
                                state_q    <= ST_CLEAR_LINE;
                            end else if (is_cr) begin
                                cursor_x_q <= '0;
                            end else if (is_bs) begin
                                if (cursor_x_q != '0) begin
                                    cursor_x_q <= cursor_x_q - 1'b1;
                                    write_en_q <= 1'b1;
                                    x_q        <= cursor_x_q - 1'b1;
                                    y_q        <= cursor_y_q;
                                    c_q        <= BLANK_CHAR;
                                end
                            end else begin
                                write_en_q <= 1'b1;
                                x_q        <= cursor_x_q;
                                y_q        <= cursor_y_q;
                                c_q        <= char_in;
                                if (cursor_x_q == X_LAST) begin
                                    cursor_x_q <= '0;
                                    cursor_y_q <= cursor_y_inc;
                                    state_q    <= ST_CLEAR_LINE;
                                end else begin
                                    cursor_x_q <= cursor_x_q + 1'b1;
                                end
                            end
                        end
                    end
                    ST_CLEAR_LINE: begin
                        write_en_q <= 1'b1;
                        x_q        <= cnt_x;
                        y_q        <= cnt_y;
                        c_q        <= BLANK_CHAR;
                        if (cnt_done) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_CLEAR_ALL: begin
                        write_en_q <= 1'b1;
                        sweep_wr_q <= 1'b1;
                        x_q        <= cnt_x;
                        y_q        <= cnt_y;
                        c_q        <= BLANK_CHAR;
                        cursor_x_q <= '0;
                        cursor_y_q <= '0;
                        if (cnt_done) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign write_en    = write_en_q;
    assign x           = x_q;
    assign y           = y_q;
    assign c_out       = c_q;
    assign cursor_x    = cursor_x_q;
    assign cursor_y    = cursor_y_q;
    assign busy        = (state_q == ST_CLEAR_ALL) || sweep_wr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: expected writes are queued as characters
// are driven and checked in order as the write port strobes.
module tb_text_console_writer;

    localparam int W  = 128;
    localparam int H  = 48;
    localparam int XW = 7;
    localparam int YW = 6;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          char_valid;
    logic [7:0]    char_in;
    logic          char_ready;
    logic          write_en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    c_out;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_total;
    int          n_bad;
    bit          in_sweep;
    int          m_cx;
    int          m_cy;

    text_console_writer dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .char_ready  (char_ready),
        .write_en    (write_en),
        .x           (x),
        .y           (y),
        .c_out       (c_out),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_wr(input int xx, input int yy, input int cc);
        logic [6:0] px;
        logic [5:0] py;
        logic [7:0] pc;
        px = xx[6:0];
        py = yy[5:0];
        pc = cc[7:0];
        return {11'b0, px, py, pc};
    endfunction

    task automatic push_line(input int row);
        for (int i = 0; i < W; i++) exp_q.push_back(pack_wr(i, row, 0));
    endtask

    task automatic push_sweep();
        for (int r = 0; r < H; r++) push_line(r);
    endtask

    // Reference cursor/terminal model applied to each accepted code
    task automatic model_accept(input logic [7:0] code);
        int ny;
        ny = (m_cy == H - 1) ? 0 : m_cy + 1;
        if (code == 8'h0A) begin
            m_cx = 0;
            m_cy = ny;
            push_line(m_cy);
        end else if (code == 8'h0D) begin
            m_cx = 0;
        end else if (code == 8'h08) begin
            if (m_cx > 0) begin
                m_cx = m_cx - 1;
                exp_q.push_back(pack_wr(m_cx, m_cy, 0));
            end
        end else begin
            exp_q.push_back(pack_wr(m_cx, m_cy, code));
            if (m_cx == W - 1) begin
                m_cx = 0;
                m_cy = ny;
                push_line(m_cy);
            end else begin
                m_cx = m_cx + 1;
            end
        end
    endtask

    // Scoreboard: every write strobe must match the head of the queue
    always @(negedge clk) begin
        if (!reset && write_en) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_write", {31'b0, write_en}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("write", {11'b0, x, y, c_out}, mon_exp);
                if (in_sweep) check_val("busy_sweep", {31'b0, busy}, 32'd1);
            end
        end
    end

    // Driver: present one code, optionally requiring immediate readiness
    task automatic send_char(input logic [7:0] code, input bit must_ready);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        if (must_ready) check_val("ready_now", {31'b0, char_ready}, 32'd1);
        while (!char_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!char_ready) begin
            check_val("ready_timeout", {31'b0, char_ready}, 32'd1);
        end else begin
            char_valid = 1'b1;
            char_in    = code;
            model_accept(code);
            @(posedge clk);
            #1;
            char_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("drain_left", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        in_sweep = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        check_val({tag, "_cx"}, {25'b0, cursor_x}, m_cx);
        check_val({tag, "_cy"}, {26'b0, cursor_y}, m_cy);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        in_sweep   = 1'b0;
        m_cx       = 0;
        m_cy       = 0;
        reset      = 1'b0;
        clear      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check_val("rst_write_en", {31'b0, write_en}, 32'd0);
        check_val("rst_x", {25'b0, x}, 32'd0);
        check_val("rst_y", {26'b0, y}, 32'd0);
        check_val("rst_c_out", {24'b0, c_out}, 32'd0);
        check_val("rst_cursor_x", {25'b0, cursor_x}, 32'd0);
        check_val("rst_cursor_y", {26'b0, cursor_y}, 32'd0);
        check_val("rst_busy", {31'b0, busy}, 32'd1);
        check_val("rst_ready", {31'b0, char_ready}, 32'd0);

        // Power-up sweep without any request
        push_sweep();
        in_sweep = 1'b1;
        #1 reset = 1'b0;
        wait_drain(7000);
        check_val("post_sweep_busy", {31'b0, busy}, 32'd0);
        check_val("post_sweep_ready", {31'b0, char_ready}, 32'd1);
        check_cursor("post_sweep");

        // Back-to-back printable characters
        send_char(8'h41, 1'b1);
        send_char(8'h42, 1'b1);
        wait_drain(50);
        check_cursor("ab");
        check_val("ab_cursor_x2", {25'b0, cursor_x}, 32'd2);

        // Full row of printables, then wrap into a blanked row 1
        send_char(8'h0D, 1'b1);
        for (int i = 0; i < W; i++) send_char(8'h20 + 8'($urandom_range(1, 90)), 1'b1);
        @(negedge clk);
        #1;
        check_val("ready_line_clear", {31'b0, char_ready}, 32'd0);
        check_val("busy_line_clear", {31'b0, busy}, 32'd0);
        wait_drain(400);
        check_cursor("wrap");
        check_val("wrap_ready", {31'b0, char_ready}, 32'd1);

        // Move to row 47, column 5, then newline wraps to row 0
        for (int i = 0; i < H - 2; i++) send_char(8'h0A, 1'b0);
        wait_drain(20000);
        for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i), 1'b0);
        wait_drain(50);
        check_cursor("at_5_47");
        send_char(8'h0A, 1'b1);
        wait_drain(400);
        check_cursor("nl_bottom");

        // Backspace at column 0 does nothing
        for (int i = 0; i < 3; i++) send_char(8'h0A, 1'b0);
        wait_drain(1000);
        send_char(8'h08, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        check_cursor("bs_col0");

        // Backspace inside a row blanks the previous column
        for (int i = 0; i < 4; i++) send_char(8'h30 + 8'($urandom_range(0, 9)), 1'b0);
        send_char(8'h08, 1'b1);
        wait_drain(50);
        check_cursor("bs_col4");

        // clear together with char_valid during a line clear
        send_char(8'h0A, 1'b1);
        repeat (10) @(negedge clk);
        #1;
        clear      = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h5A;
        check_val("ready_with_clear", {31'b0, char_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear      = 1'b0;
        char_valid = 1'b0;
        exp_q.delete();
        m_cx = 0;
        m_cy = 0;
        push_sweep();
        in_sweep = 1'b1;
        @(negedge clk);
        check_val("busy_after_clear", {31'b0, busy}, 32'd1);
        wait_drain(7000);
        check_cursor("after_clear");
        check_val("after_clear_busy", {31'b0, busy}, 32'd0);
        check_val("after_clear_ready", {31'b0, char_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
